keypad_entry_controller: RTL and testbench
==========================================

# keypad_entry_controller

Sequences the keypad front end of the DigiLock: synchronizes and debounces the ten one-hot decimal key lines and converts each valid key press to BCD through the existing `decimal_bcd_encoder`. It accumulates NUM_DIGITS digits into a code buffer and presents the completed code to the lock FSM through a ready/ack handshake. Sits between the physical keypad and the password comparator.

## Interface

Parameters:

- `DEBOUNCE_CYCLES`, default 4. Consecutive stable cycles required on press and on release. Legal range 2–255.
- `NUM_DIGITS`, default 4. Code length in digits. Legal range 1–8.

Ports:

- `clock`, input, 1 bit. Single clock, rising edge.
- `reset_n`, input, 1 bit. Asynchronous, active-low reset.
- `enable`, input, 1 bit. When low, new presses are not accepted (IDLE holds).
- `keys`, input, 10 bits. Raw key lines; bit i set means key i is pressed. Asynchronous to `clock`.
- `clear`, input, 1 bit. Synchronous buffer clear.
- `ack`, input, 1 bit. Consumer has taken the code.
- `digit_valid`, output, 1 bit. One-cycle pulse when a digit is captured.
- `digit_bcd`, output, 4 bits. BCD of the digit being captured; valid while `digit_valid` is high.
- `key_error`, output, 1 bit. One-cycle pulse when a multi-key press is detected.
- `count`, output, `$clog2(NUM_DIGITS+1)` bits. Number of digits held.
- `digits`, output, 4*NUM_DIGITS bits. Code buffer; the newest digit is in bits [3:0].
- `code_ready`, output, 1 bit. High while the buffer is full and awaiting `ack`.

## Operation

- Input path: a two-flop synchronizer on `keys` produces `ks`. All decisions use `ks`.
- States: IDLE, DEBOUNCE, CAPTURE, WAIT_RELEASE, FULL.
- IDLE:
  - `ks`==0, or `enable`=0: stay.
  - Exactly one bit set: latch `ks` into `kl`, set `dcnt`=0, go to DEBOUNCE.
  - Two or more bits set: pulse `key_error`, go to WAIT_RELEASE.
- DEBOUNCE:
  - `ks`≠`kl`: go to IDLE, no capture.
  - Otherwise, if `dcnt`==DEBOUNCE_CYCLES-1, go to CAPTURE; else increment `dcnt`.
- CAPTURE (one cycle):
  - `digit_valid`=1 and `digit_bcd`=encoder(`kl`), combinational from state.
  - On exit, `digits` ← {`digits`[4*NUM_DIGITS-5:0], `digit_bcd`} and `count`++.
  - Go to WAIT_RELEASE.
- WAIT_RELEASE:
  - Count consecutive cycles with `ks`==0; any nonzero `ks` resets the count.
  - On reaching DEBOUNCE_CYCLES: go to FULL if `count`==NUM_DIGITS, else IDLE.
- FULL:
  - `code_ready`=1 and `keys` are ignored.
  - On `ack`: `digits`←0, `count`←0, go to IDLE.
- `clear` (priority over everything except reset): `digits`←0, `count`←0, `dcnt`←0, go to WAIT_RELEASE. This applies in every state, including FULL and CAPTURE; a capture coinciding with `clear` is discarded.
- `ack` outside FULL is ignored.
- `count` never exceeds NUM_DIGITS, and the buffer never wraps.

## Timing

- Reset values:
  - State IDLE.
  - `digits`=0, `count`=0.
  - `digit_valid`=0, `key_error`=0, `code_ready`=0, `digit_bcd`=0.
  - Synchronizer flops and counters 0.
- Reset mid-operation returns to exactly these values asynchronously; a partial press is lost.
- Press latency: a key first sampled at edge 1 puts `ks` valid at edge 2 and DEBOUNCE at edge 3. `digit_valid` rises after edge DEBOUNCE_CYCLES+3 (edge 7 for default 4) and is high for exactly one cycle.
- `digits` and `count` update at edge DEBOUNCE_CYCLES+4.
- Minimum hold for acceptance: DEBOUNCE_CYCLES+1 cycles stable.
- `key_error` is high in the cycle after the IDLE edge that saw multi-hot `ks`.
- `code_ready` rises DEBOUNCE_CYCLES cycles after the last key's release is seen on `ks`. It falls the cycle after `ack` is sampled.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Structure

- Shared header `digilock_defs.vh` holds:
  - State encodings (3-bit binary).
  - Key constants KEY_0..KEY_9 (one-hot patterns).
  - Default DEBOUNCE_CYCLES and NUM_DIGITS.
- One sub-module instance: `decimal_bcd_encoder` (existing), driven by `kl`.
- The synchronizer and counters stay inline.

## Test plan

- Reset: assert `reset_n`=0 mid-DEBOUNCE of key 7 → all outputs at reset values immediately. After release, with no new press, `count` stays 0.
- Full code: press keys 1, 9, 4, 0 in sequence (10'b0000000010, 10'b1000000000, 10'b0000010000, 10'b0000000001), each held 10 cycles and released 10 cycles.
  - Four `digit_valid` pulses with `digit_bcd` 1, 9, 4, 0.
  - `digit_valid` first high at edge 7 after the first press.
  - `digits`=16'h1940, `count`=4, `code_ready`=1.
- Bounce: key 5 held 3 cycles, low 1 cycle, held 3 cycles → no `digit_valid` and `count` unchanged. Key 5 then held 10 cycles → `digit_bcd`=5, `count`=1.
- Multi-key: `keys`=10'b0000100100 held 10 cycles → one `key_error` pulse, no capture. A following key 3 is accepted only after DEBOUNCE_CYCLES idle cycles.
- Full/ack/clear:
  - While FULL, press key 8 → ignored.
  - `ack` → `digits`=0, `count`=0, `code_ready`=0 next cycle.
  - Enter 2 digits, then pulse `clear` → `count`=0.
- `enable`=0: press key 6 for 20 cycles → no capture. Raise `enable` while key 6 is still held → captured with `digit_bcd`=6.

Source files
------------

// File: rtl/keypad_entry_controller_pkg.sv
// rtl/keypad_entry_controller_pkg.sv - shared state encodings, key patterns and defaults for the keypad front end
package keypad_entry_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_DEBOUNCE     = 3'd1,
    ST_CAPTURE      = 3'd2,
    ST_WAIT_RELEASE = 3'd3,
    ST_FULL         = 3'd4
  } state_t;

  localparam logic [9:0] KEY_0 = 10'b0000000001;
  localparam logic [9:0] KEY_1 = 10'b0000000010;
  localparam logic [9:0] KEY_2 = 10'b0000000100;
  localparam logic [9:0] KEY_3 = 10'b0000001000;
  localparam logic [9:0] KEY_4 = 10'b0000010000;
  localparam logic [9:0] KEY_5 = 10'b0000100000;
  localparam logic [9:0] KEY_6 = 10'b0001000000;
  localparam logic [9:0] KEY_7 = 10'b0010000000;
  localparam logic [9:0] KEY_8 = 10'b0100000000;
  localparam logic [9:0] KEY_9 = 10'b1000000000;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_NUM_DIGITS      = 4;

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  function automatic logic is_one_hot(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

endpackage

// File: rtl/decimal_bcd_encoder.sv
// rtl/decimal_bcd_encoder.sv - one-hot decimal key pattern to BCD digit
module decimal_bcd_encoder
  import keypad_entry_controller_pkg::*;
(
  input  logic [9:0] onehot,
  output logic [3:0] bcd
);

  always_comb begin
    bcd = 4'd0;
    case (onehot)
      KEY_0:   bcd = 4'd0;
      KEY_1:   bcd = 4'd1;
      KEY_2:   bcd = 4'd2;
      KEY_3:   bcd = 4'd3;
      KEY_4:   bcd = 4'd4;
      KEY_5:   bcd = 4'd5;
      KEY_6:   bcd = 4'd6;
      KEY_7:   bcd = 4'd7;
      KEY_8:   bcd = 4'd8;
      KEY_9:   bcd = 4'd9;
      default: bcd = 4'd0;
    endcase
  end

endmodule

// File: rtl/keypad_entry_controller.sv
// rtl/keypad_entry_controller.sv - debounces keypad presses and assembles a multi-digit code with ready/ack
module keypad_entry_controller
  import keypad_entry_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int NUM_DIGITS      = DEFAULT_NUM_DIGITS
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [9:0]                      keys,
  input  logic                            clear,
  input  logic                            ack,
  output logic                            digit_valid,
  output logic [3:0]                      digit_bcd,
  output logic                            key_error,
  output logic [$clog2(NUM_DIGITS+1)-1:0] count,
  output logic [4*NUM_DIGITS-1:0]         digits,
  output logic                            code_ready
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [7:0]    DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(NUM_DIGITS);

  state_t      state, state_next;
  logic [9:0]  sync1, ks, kl;
  logic [7:0]  dcnt, rcnt;
  logic [3:0]  enc_bcd;
  logic        key_error_q;

  decimal_bcd_encoder u_encoder (
    .onehot (kl),
    .bcd    (enc_bcd)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      ks    <= '0;
    end else begin
      sync1 <= keys;
      ks    <= sync1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_WAIT_RELEASE;
    end else begin
      case (state)
        ST_IDLE:
          if (enable && ks != 10'd0)
            state_next = is_one_hot(ks) ? ST_DEBOUNCE : ST_WAIT_RELEASE;
        ST_DEBOUNCE:
          if (ks != kl)            state_next = ST_IDLE;
          else if (dcnt == DB_LAST) state_next = ST_CAPTURE;
        ST_CAPTURE:
          state_next = ST_WAIT_RELEASE;
        ST_WAIT_RELEASE:
          if (ks == 10'd0 && rcnt == DB_LAST)
            state_next = (count == COUNT_MAX) ? ST_FULL : ST_IDLE;
        ST_FULL:
          if (ack) state_next = ST_IDLE;
        default:
          state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath registers; clear outranks any capture or ack in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      kl          <= '0;
      dcnt        <= '0;
      rcnt        <= '0;
      digits      <= '0;
      count       <= '0;
      key_error_q <= 1'b0;
    end else if (clear) begin
      dcnt        <= '0;
      rcnt        <= '0;
      digits      <= '0;
      count       <= '0;
      key_error_q <= 1'b0;
    end else begin
      key_error_q <= (state == ST_IDLE) && enable && (ks != 10'd0) && !is_one_hot(ks);
      case (state)
        ST_IDLE: begin
          rcnt <= '0;
          if (enable && is_one_hot(ks)) begin
            kl   <= ks;
            dcnt <= '0;
          end
        end
        ST_DEBOUNCE:
          if (ks == kl && dcnt != DB_LAST) dcnt <= dcnt + 8'd1;
        ST_CAPTURE: begin
          rcnt <= '0;
          if (count != COUNT_MAX) begin
            digits <= (digits << 4) | DW'(enc_bcd);
            count  <= count + CW'(1);
          end
        end
        ST_WAIT_RELEASE:
          rcnt <= (ks != 10'd0) ? 8'd0 : rcnt + 8'd1;
        ST_FULL:
          if (ack) begin
            digits <= '0;
            count  <= '0;
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    digit_valid = (state == ST_CAPTURE);
    digit_bcd   = (state == ST_CAPTURE) ? enc_bcd : 4'd0;
    code_ready  = (state == ST_FULL);
    key_error   = key_error_q;
  end

endmodule

// File: tb/tb_keypad_entry_controller.sv
// tb/tb_keypad_entry_controller.sv - directed self-checking bench for keypad_entry_controller
module tb_keypad_entry_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [9:0]  keys;
  logic        clear;
  logic        ack;
  logic        digit_valid;
  logic [3:0]  digit_bcd;
  logic        key_error;
  logic [2:0]  count;
  logic [15:0] digits;
  logic        code_ready;

  int checks = 0;
  int fails  = 0;
  logic [3:0] dv_log[$];
  int err_pulses = 0;

  keypad_entry_controller dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .keys        (keys),
    .clear       (clear),
    .ack         (ack),
    .digit_valid (digit_valid),
    .digit_bcd   (digit_bcd),
    .key_error   (key_error),
    .count       (count),
    .digits      (digits),
    .code_ready  (code_ready)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (digit_valid) dv_log.push_back(digit_bcd);
    if (key_error) err_pulses++;
  end

  task automatic press(input logic [9:0] k, input int hold, input int rel);
    keys = k;
    repeat (hold) @(negedge clock);
    keys = 10'd0;
    repeat (rel) @(negedge clock);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    repeat (8) @(negedge clock);
    dv_log.delete();
    err_pulses = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; keys = 10'd0; clear = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({digit_valid, key_error, code_ready, digit_bcd, count, digits} !== 26'd0) begin
      fails++;
      $display("FAIL reset_values: got dv=%b ke=%b cr=%b bcd=%h cnt=%0d dig=%h, want all 0",
               digit_valid, key_error, code_ready, digit_bcd, count, digits);
    end
    reset_n = 1'b1;
    @(negedge clock);
    keys = 10'b0010000000;
    repeat (4) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({digit_valid, key_error, code_ready, digit_bcd, count, digits} !== 26'd0) begin
      fails++;
      $display("FAIL reset_async: got dv=%b ke=%b cr=%b bcd=%h cnt=%0d dig=%h, want all 0",
               digit_valid, key_error, code_ready, digit_bcd, count, digits);
    end
    keys = 10'd0;
    @(negedge clock);
    reset_n = 1'b1;
    dv_log.delete();
    repeat (20) @(negedge clock);
    checks++;
    if (count !== 3'd0 || dv_log.size() != 0) begin
      fails++;
      $display("FAIL reset_no_capture: got count=%0d pulses=%0d, want 0 0", count, dv_log.size());
    end
  endtask

  task automatic test_full_code();
    logic [3:0] want[4];
    logic       dv_at[9];
    want = '{4'd1, 4'd9, 4'd4, 4'd0};
    dv_log.delete();
    keys = 10'b0000000010;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clock);
      dv_at[e] = digit_valid;
    end
    checks++;
    if (dv_at[6] !== 1'b0 || dv_at[7] !== 1'b1 || dv_at[8] !== 1'b0) begin
      fails++;
      $display("FAIL latency: got dv e6/e7/e8=%b%b%b, want 010", dv_at[6], dv_at[7], dv_at[8]);
    end
    checks++;
    if (count !== 3'd1) begin
      fails++;
      $display("FAIL count_after_edge8: got %0d, want 1", count);
    end
    repeat (2) @(negedge clock);
    keys = 10'd0;
    repeat (10) @(negedge clock);
    press(10'b1000000000, 10, 10);
    press(10'b0000010000, 10, 10);
    press(10'b0000000001, 10, 10);
    checks++;
    if (dv_log.size() != 4) begin
      fails++;
      $display("FAIL full_pulses: got %0d, want 4", dv_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dv_log[i] !== want[i]) begin
          fails++;
          $display("FAIL full_bcd[%0d]: got %0d, want %0d", i, dv_log[i], want[i]);
        end
      end
    end
    checks++;
    if (digits !== 16'h1940 || count !== 3'd4 || code_ready !== 1'b1) begin
      fails++;
      $display("FAIL full_code: got dig=%h cnt=%0d cr=%b, want 1940 4 1", digits, count, code_ready);
    end
  endtask

  task automatic test_full_ack_clear();
    dv_log.delete();
    press(10'b0100000000, 10, 10);
    checks++;
    if (dv_log.size() != 0 || digits !== 16'h1940 || code_ready !== 1'b1) begin
      fails++;
      $display("FAIL full_ignores_keys: got pulses=%0d dig=%h cr=%b, want 0 1940 1",
               dv_log.size(), digits, code_ready);
    end
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    checks++;
    if (digits !== 16'h0 || count !== 3'd0 || code_ready !== 1'b0) begin
      fails++;
      $display("FAIL ack: got dig=%h cnt=%0d cr=%b, want 0 0 0", digits, count, code_ready);
    end
    repeat (3) @(negedge clock);
    press(10'b0000000100, 10, 10);
    press(10'b0000001000, 10, 10);
    checks++;
    if (digits !== 16'h0023 || count !== 3'd2) begin
      fails++;
      $display("FAIL two_digits: got dig=%h cnt=%0d, want 0023 2", digits, count);
    end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    checks++;
    if (digits !== 16'h0 || count !== 3'd0) begin
      fails++;
      $display("FAIL clear: got dig=%h cnt=%0d, want 0 0", digits, count);
    end
    repeat (8) @(negedge clock);
  endtask

  task automatic test_bounce();
    pulse_clear();
    keys = 10'b0000100000;
    repeat (3) @(negedge clock);
    keys = 10'd0;
    @(negedge clock);
    keys = 10'b0000100000;
    repeat (3) @(negedge clock);
    keys = 10'd0;
    repeat (10) @(negedge clock);
    checks++;
    if (dv_log.size() != 0 || count !== 3'd0) begin
      fails++;
      $display("FAIL bounce: got pulses=%0d cnt=%0d, want 0 0", dv_log.size(), count);
    end
    press(10'b0000100000, 10, 10);
    checks++;
    if (dv_log.size() != 1 || dv_log[0] !== 4'd5 || count !== 3'd1 || digits !== 16'h0005) begin
      fails++;
      $display("FAIL bounce_then_hold: got pulses=%0d cnt=%0d dig=%h, want 1 1 0005",
               dv_log.size(), count, digits);
    end
  endtask

  task automatic test_multi_key();
    pulse_clear();
    keys = 10'b0000100100;
    repeat (10) @(negedge clock);
    keys = 10'd0;
    repeat (2) @(negedge clock);
    press(10'b0000001000, 10, 10);
    checks++;
    if (err_pulses != 1 || dv_log.size() != 0 || count !== 3'd0) begin
      fails++;
      $display("FAIL multi_key: got errs=%0d pulses=%0d cnt=%0d, want 1 0 0",
               err_pulses, dv_log.size(), count);
    end
    press(10'b0000001000, 10, 10);
    checks++;
    if (err_pulses != 1 || dv_log.size() != 1 || dv_log[0] !== 4'd3 || count !== 3'd1) begin
      fails++;
      $display("FAIL multi_then_key3: got errs=%0d pulses=%0d cnt=%0d, want 1 1 1",
               err_pulses, dv_log.size(), count);
    end
  endtask

  task automatic test_min_hold();
    pulse_clear();
    press(10'b0000000100, 4, 10);
    checks++;
    if (dv_log.size() != 0) begin
      fails++;
      $display("FAIL hold_4: got pulses=%0d, want 0", dv_log.size());
    end
    press(10'b0000000100, 5, 10);
    checks++;
    if (dv_log.size() != 1 || dv_log[0] !== 4'd2 || count !== 3'd1) begin
      fails++;
      $display("FAIL hold_5: got pulses=%0d cnt=%0d, want 1 1", dv_log.size(), count);
    end
  endtask

  task automatic test_enable();
    pulse_clear();
    enable = 1'b0;
    keys = 10'b0001000000;
    repeat (20) @(negedge clock);
    checks++;
    if (dv_log.size() != 0 || count !== 3'd0) begin
      fails++;
      $display("FAIL enable_low: got pulses=%0d cnt=%0d, want 0 0", dv_log.size(), count);
    end
    enable = 1'b1;
    repeat (10) @(negedge clock);
    keys = 10'd0;
    repeat (10) @(negedge clock);
    checks++;
    if (dv_log.size() != 1 || dv_log[0] !== 4'd6 || count !== 3'd1 || digits !== 16'h0006) begin
      fails++;
      $display("FAIL enable_high: got pulses=%0d cnt=%0d dig=%h, want 1 1 0006",
               dv_log.size(), count, digits);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || digits !== 16'h0) begin
      fails++;
      $display("FAIL reset_loaded: got cnt=%0d dig=%h, want 0 0", count, digits);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_full_code();
    test_full_ack_clear();
    test_bounce();
    test_multi_key();
    test_min_hold();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
